// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: independent write and read burst engines over a single word array.
// Supports FIXED/INCR/WRAP bursts, byte strobes, ID echo and SLVERR reporting.
module axi4_slave_mem #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int MEM_WORDS  = 1024
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic [ID_WIDTH-1:0]     AWID,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic [7:0]              AWLEN,
   input  logic [1:0]              AWBURST,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WLAST,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [ID_WIDTH-1:0]     BID,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ID_WIDTH-1:0]     ARID,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic [7:0]              ARLEN,
   input  logic [1:0]              ARBURST,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [ID_WIDTH-1:0]     RID,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RLAST,
   output logic                    RVALID,
   input  logic                    RREADY
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int ASZ        = $clog2(STRB_WIDTH);
   localparam int MW         = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] ALIGN = ADDR_WIDTH'(STRB_WIDTH - 1);
   localparam logic [1:0] B_FIXED = 2'b00, B_WRAP = 2'b10;
   localparam logic [1:0] RESP_OK = 2'b00, RESP_SLVERR = 2'b10;
   localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0, R_DATA = 1'b1;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0] len,
                                                        input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] al, inc, wm;
      al  = a & ~ALIGN;
      inc = al + ADDR_WIDTH'(STRB_WIDTH);
      wm  = ((ADDR_WIDTH'(len) + 1'b1) << ASZ) - 1'b1;
      case (burst)
         B_FIXED: next_addr = al;
         B_WRAP:  next_addr = (al & ~wm) | (inc & wm);
         default: next_addr = inc;
      endcase
   endfunction

   // Reserved burst type or an illegal WRAP length poisons the whole burst.
   function automatic logic bad_burst(input logic [7:0] len, input logic [1:0] burst);
      bad_burst = (burst == 2'b11) ||
                  (burst == B_WRAP && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15);
   endfunction

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      in_range = (a >> ASZ) < ADDR_WIDTH'(MEM_WORDS);
   endfunction

   function automatic logic [MW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      word_idx = MW'(a >> ASZ);
   endfunction

   // ---------------- write engine ----------------
   logic [1:0]            w_state;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [7:0]            wlen, wcnt;
   logic [1:0]            wburst;
   logic [ID_WIDTH-1:0]   wid;
   logic                  werr, wbad;
   logic                  wbeat, wlast_beat, wbeat_err, wr_en;

   always_comb begin
      wbeat      = (w_state == W_DATA) && WVALID && WREADY;
      wlast_beat = (wcnt == wlen);
      wbeat_err  = wbad || !in_range(waddr) || (WLAST != wlast_beat);
      wr_en      = wbeat && !wbad && in_range(waddr);
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         w_state <= W_IDLE;
         AWREADY <= 1'b0;
         WREADY  <= 1'b0;
         BVALID  <= 1'b0;
         BID     <= '0;
         BRESP   <= RESP_OK;
         waddr   <= '0;
         wlen    <= '0;
         wcnt    <= '0;
         wburst  <= '0;
         wid     <= '0;
         werr    <= 1'b0;
         wbad    <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (AWVALID && AWREADY) begin
                  wid     <= AWID;
                  waddr   <= AWADDR;
                  wlen    <= AWLEN;
                  wburst  <= AWBURST;
                  wbad    <= bad_burst(AWLEN, AWBURST);
                  wcnt    <= '0;
                  werr    <= 1'b0;
                  AWREADY <= 1'b0;
                  WREADY  <= 1'b1;
                  w_state <= W_DATA;
               end else begin
                  AWREADY <= 1'b1;
               end
            end
            W_DATA: begin
               if (wbeat) begin
                  werr <= werr | wbeat_err;
                  if (wlast_beat) begin
                     WREADY  <= 1'b0;
                     BVALID  <= 1'b1;
                     BID     <= wid;
                     BRESP   <= (werr | wbeat_err) ? RESP_SLVERR : RESP_OK;
                     w_state <= W_RESP;
                  end else begin
                     wcnt  <= wcnt + 8'd1;
                     waddr <= next_addr(waddr, wlen, wburst);
                  end
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  BVALID  <= 1'b0;
                  BRESP   <= RESP_OK;
                  AWREADY <= 1'b1;
                  w_state <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Memory array has no reset; contents survive ARESETn.
   always_ff @(posedge ACLK) begin
      if (wr_en) begin
         for (int b = 0; b < STRB_WIDTH; b++)
            if (WSTRB[b]) mem[word_idx(waddr)][8*b +: 8] <= WDATA[8*b +: 8];
      end
   end

   // ---------------- read engine ----------------
   logic [0:0]            r_state;
   logic [ADDR_WIDTH-1:0] raddr, f_addr;
   logic [7:0]            rlen, rcnt;
   logic [1:0]            rburst;
   logic                  rbad, f_bad, f_ok;
   logic [DATA_WIDTH-1:0] f_data;

   // Fetch address for the beat presented next; sampled before any same-edge write lands.
   always_comb begin
      f_addr = (r_state == R_IDLE) ? ARADDR : next_addr(raddr, rlen, rburst);
      f_bad  = (r_state == R_IDLE) ? bad_burst(ARLEN, ARBURST) : rbad;
      f_ok   = in_range(f_addr) && !f_bad;
      f_data = f_ok ? mem[word_idx(f_addr)] : '0;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state <= R_IDLE;
         ARREADY <= 1'b0;
         RVALID  <= 1'b0;
         RID     <= '0;
         RDATA   <= '0;
         RRESP   <= RESP_OK;
         RLAST   <= 1'b0;
         raddr   <= '0;
         rlen    <= '0;
         rcnt    <= '0;
         rburst  <= '0;
         rbad    <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ARVALID && ARREADY) begin
                  RID     <= ARID;
                  raddr   <= ARADDR;
                  rlen    <= ARLEN;
                  rburst  <= ARBURST;
                  rbad    <= f_bad;
                  rcnt    <= '0;
                  ARREADY <= 1'b0;
                  RVALID  <= 1'b1;
                  RDATA   <= f_data;
                  RRESP   <= f_ok ? RESP_OK : RESP_SLVERR;
                  RLAST   <= (ARLEN == 8'd0);
                  r_state <= R_DATA;
               end else begin
                  ARREADY <= 1'b1;
               end
            end
            R_DATA: begin
               if (RREADY) begin
                  if (rcnt == rlen) begin
                     RVALID  <= 1'b0;
                     RLAST   <= 1'b0;
                     RDATA   <= '0;
                     RRESP   <= RESP_OK;
                     ARREADY <= 1'b1;
                     r_state <= R_IDLE;
                  end else begin
                     rcnt  <= rcnt + 8'd1;
                     raddr <= f_addr;
                     RDATA <= f_data;
                     RRESP <= f_ok ? RESP_OK : RESP_SLVERR;
                     RLAST <= (rcnt + 8'd1 == rlen);
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: bursts, strobes, wrap, errors, backpressure, reset.
module tb_axi4_slave_mem;
   logic        ACLK, ARESETn;
   logic [3:0]  AWID, BID, ARID, RID;
   logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
   logic [7:0]  AWLEN, ARLEN;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic [3:0]  WSTRB;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

   int nchk = 0, nerr = 0;
   logic [31:0] rdat [16];
   logic [1:0]  rrsp [16];
   logic        rlst [16];
   logic [3:0]  rid_got;
   logic [3:0]  bid;
   logic [1:0]  bresp;

   axi4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_WORDS(1024)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Data of beat i is base+i; WLAST is driven correctly.
   task automatic axi_wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [3:0] strb, input logic [31:0] base,
                         input int bstall, output logic [3:0] obid, output logic [1:0] oresp);
      int n;
      AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
      n = 0;
      while (!AWREADY && n < 100) begin tick(); n++; end
      chk("aw_ready", AWREADY, 1);
      tick();
      AWVALID = 1'b0;
      for (int i = 0; i <= len; i++) begin
         WDATA = base + i; WSTRB = strb; WLAST = (i == len); WVALID = 1'b1;
         n = 0;
         while (!WREADY && n < 100) begin tick(); n++; end
         chk("w_ready", WREADY, 1);
         tick();
      end
      WVALID = 1'b0; WLAST = 1'b0;
      n = 0;
      while (!BVALID && n < 100) begin tick(); n++; end
      chk("b_valid", BVALID, 1);
      obid = BID; oresp = BRESP;
      for (int k = 0; k < bstall; k++) begin
         tick();
         chk("b_hold_valid", BVALID, 1);
         chk("b_hold_id", BID, obid);
         chk("aw_blocked", AWREADY, 0);
      end
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
   endtask

   task automatic axi_rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int stall_beat);
      int n;
      logic [31:0] sd;
      logic        sl;
      ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
      n = 0;
      while (!ARREADY && n < 100) begin tick(); n++; end
      chk("ar_ready", ARREADY, 1);
      tick();
      ARVALID = 1'b0;
      RREADY = 1'b1;
      for (int i = 0; i <= len; i++) begin
         n = 0;
         while (!RVALID && n < 100) begin tick(); n++; end
         chk("r_valid", RVALID, 1);
         if (i == stall_beat) begin
            RREADY = 1'b0;
            sd = RDATA; sl = RLAST;
            for (int k = 0; k < 3; k++) begin
               tick();
               chk("r_hold_valid", RVALID, 1);
               chk("r_hold_data", RDATA, sd);
               chk("r_hold_last", RLAST, sl);
            end
            RREADY = 1'b1;
         end
         rdat[i] = RDATA; rrsp[i] = RRESP; rlst[i] = RLAST; rid_got = RID;
         tick();
      end
      RREADY = 1'b0;
   endtask

   initial begin
      logic seen_b;
      logic [31:0] exp4 [4];
      ARESETn = 1'b0;
      AWID = '0; AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      ARID = '0; ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
      repeat (3) tick();
      chk("rst_awready", AWREADY, 0);
      chk("rst_arready", ARREADY, 0);
      chk("rst_bvalid", BVALID, 0);
      chk("rst_rvalid", RVALID, 0);
      ARESETn = 1'b1;
      #1;
      chk("rel_awready_low", AWREADY, 0);
      tick();
      chk("rel_awready", AWREADY, 1);
      chk("rel_arready", ARREADY, 1);

      // 1: INCR write/read, ID echo and RLAST placement
      axi_wr(4'd5, 32'h10, 8'd3, 2'b01, 4'hF, 32'hA0, 0, bid, bresp);
      chk("t1_bid", bid, 5);
      chk("t1_bresp", bresp, 0);
      axi_rd(4'd9, 32'h10, 8'd3, 2'b01, -1);
      chk("t1_rid", rid_got, 9);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_rdata%0d", i), rdat[i], 32'hA0 + i);
         chk($sformatf("t1_rlast%0d", i), rlst[i], (i == 3));
         chk($sformatf("t1_rresp%0d", i), rrsp[i], 0);
      end

      // 2: byte strobes over a preloaded word
      axi_wr(4'd1, 32'h8, 8'd0, 2'b01, 4'hF, 32'hFFFFFFFF, 0, bid, bresp);
      axi_wr(4'd1, 32'h8, 8'd0, 2'b01, 4'b0101, 32'h11223344, 0, bid, bresp);
      axi_rd(4'd1, 32'h8, 8'd0, 2'b01, -1);
      chk("t2_strb", rdat[0], 32'hFF22FF44);

      // 3: WRAP from 0x18 lands C0@18 C1@1C C2@10 C3@14
      axi_wr(4'd2, 32'h18, 8'd3, 2'b10, 4'hF, 32'hC0, 0, bid, bresp);
      chk("t3_wrap_bresp", bresp, 0);
      exp4[0] = 32'hC2; exp4[1] = 32'hC3; exp4[2] = 32'hC0; exp4[3] = 32'hC1;
      axi_rd(4'd2, 32'h10, 8'd3, 2'b01, -1);
      for (int i = 0; i < 4; i++) chk($sformatf("t3_wrap_mem%0d", i), rdat[i], exp4[i]);
      axi_rd(4'd2, 32'h18, 8'd3, 2'b10, -1);
      for (int i = 0; i < 4; i++) chk($sformatf("t3_wrap_rd%0d", i), rdat[i], 32'hC0 + i);
      axi_wr(4'd3, 32'h10, 8'd2, 2'b10, 4'hF, 32'hD0, 0, bid, bresp);
      chk("t3_badwrap_bresp", bresp, 2'b10);
      axi_rd(4'd3, 32'h10, 8'd3, 2'b01, -1);
      for (int i = 0; i < 4; i++) chk($sformatf("t3_badwrap_mem%0d", i), rdat[i], exp4[i]);

      // 4: out-of-range and reserved burst
      axi_wr(4'd4, 32'h1000, 8'd0, 2'b01, 4'hF, 32'hBEEF, 0, bid, bresp);
      chk("t4_oor_bresp", bresp, 2'b10);
      axi_rd(4'd4, 32'h1000, 8'd0, 2'b01, -1);
      chk("t4_oor_rresp", rrsp[0], 2'b10);
      chk("t4_oor_rdata", rdat[0], 0);
      axi_wr(4'd4, 32'h20, 8'd0, 2'b01, 4'hF, 32'h12345678, 0, bid, bresp);
      axi_wr(4'd6, 32'h20, 8'd0, 2'b11, 4'hF, 32'hE0, 0, bid, bresp);
      chk("t4_rsv_bresp", bresp, 2'b10);
      chk("t4_rsv_bid", bid, 6);
      axi_rd(4'd4, 32'h20, 8'd0, 2'b01, -1);
      chk("t4_rsv_mem", rdat[0], 32'h12345678);
      chk("t4_rsv_mem_resp", rrsp[0], 0);

      // 5: R and B backpressure
      axi_rd(4'd7, 32'h10, 8'd3, 2'b01, 1);
      for (int i = 0; i < 4; i++) chk($sformatf("t5_rdata%0d", i), rdat[i], exp4[i]);
      chk("t5_rlast3", rlst[3], 1);
      axi_wr(4'd12, 32'h30, 8'd0, 2'b01, 4'hF, 32'h77, 5, bid, bresp);
      chk("t5_bid", bid, 12);
      chk("t5_bresp", bresp, 0);

      // 6: reset in the middle of a len-7 write
      AWID = 4'd8; AWADDR = 32'h40; AWLEN = 8'd7; AWBURST = 2'b01; AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      for (int i = 0; i < 2; i++) begin
         WDATA = 32'h50 + i; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
         chk("t6_wready", WREADY, 1);
         tick();
      end
      WDATA = 32'h52;
      ARESETn = 1'b0;
      #1;
      chk("t6_rst_awready", AWREADY, 0);
      chk("t6_rst_wready", WREADY, 0);
      chk("t6_rst_bvalid", BVALID, 0);
      chk("t6_rst_bid", BID, 0);
      chk("t6_rst_arready", ARREADY, 0);
      chk("t6_rst_rvalid", RVALID, 0);
      WVALID = 1'b0;
      tick(); tick();
      ARESETn = 1'b1;
      BREADY = 1'b1;
      seen_b = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         seen_b = seen_b | BVALID;
      end
      BREADY = 1'b0;
      chk("t6_no_bresp", seen_b, 0);
      axi_rd(4'd8, 32'h40, 8'd1, 2'b01, -1);
      chk("t6_rd0", rdat[0], 32'h50);
      chk("t6_rd1", rdat[1], 32'h51);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
Synthesizable AXI4 slave memory that terminates the AW/W/B/AR/R channels presented by the master agent and serves as the default DUT/responder on the SLAVE side of the AXI interface. It supports parametrised widths and depth, FIXED/INCR/WRAP bursts, byte strobes, ID echo and SLVERR generation, with independent write and read engines.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, data bus width in bits (32/64/128); STRB_WIDTH = DATA_WIDTH/8 is derived internally.
ID_WIDTH, 4, transaction ID width.
MEM_WORDS, 1024, memory depth in DATA_WIDTH words; word index = addr >> log2(STRB_WIDTH).

Ports:
ACLK  in  1  global clock; all logic on posedge.
ARESETn  in  1  asynchronous, active-low reset.
AWID  in  ID_WIDTH  write ID.
AWADDR  in  ADDR_WIDTH  write start byte address.
AWLEN  in  8  beats-1.
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
AWVALID  in  1  AW valid.
AWREADY  out  1  AW ready.
WDATA  in  DATA_WIDTH  write data.
WSTRB  in  STRB_WIDTH  byte enables.
WLAST  in  1  last write beat.
WVALID  in  1  W valid.
WREADY  out  1  W ready.
BID  out  ID_WIDTH  echoed AWID.
BRESP  out  2  00 OKAY, 10 SLVERR.
BVALID  out  1  B valid.
BREADY  in  1  B ready.
ARID  in  ID_WIDTH  read ID.
ARADDR  in  ADDR_WIDTH  read start byte address.
ARLEN  in  8  beats-1.
ARBURST  in  2  burst type (as AWBURST).
ARVALID  in  1  AR valid.
ARREADY  out  1  AR ready.
RID  out  ID_WIDTH  echoed ARID.
RDATA  out  DATA_WIDTH  read data.
RRESP  out  2  per-beat response.
RLAST  out  1  last read beat.
RVALID  out  1  R valid.
RREADY  in  1  R ready.

Behaviour:
- Reset (ARESETn low, async): all outputs 0, so every VALID/READY is low. Both FSMs go to IDLE and any in-flight burst is discarded with no B/R emitted. Memory contents are not reset. First AWREADY/ARREADY high on the first posedge after release.
- Write FSM, W_IDLE: AWREADY=1. On AWVALID&&AWREADY, latch ID/addr/len/burst, clear the beat counter and error flag, then go to W_DATA (AWREADY=0, WREADY=1).
- W_DATA: each WVALID&&WREADY beat writes the bytes enabled by WSTRB to mem[word] and advances the address. The beat at counter==len goes to W_RESP with WREADY=0. A WLAST mismatch (early, or missing on the final beat) sets the error flag; the burst still ends at counter==len.
- W_RESP: BVALID=1, BID=latched ID, BRESP=SLVERR if the error flag is set, else OKAY. BID/BRESP/BVALID hold until BREADY, then go to W_IDLE. AW is not accepted during W_DATA or W_RESP.
- Read FSM, R_IDLE: ARREADY=1. On handshake, go to R_DATA. RVALID rises the cycle after the AR handshake, with RDATA/RRESP/RLAST registered. Outputs hold stable while RVALID&&!RREADY.
- R_DATA: each R handshake advances the address and presents the next beat in the next cycle (one beat per cycle under RREADY=1). RLAST=1 only on beat len. The last handshake returns to R_IDLE.
- Address (size is always the full bus): low log2(STRB_WIDTH) address bits are ignored (aligned down).
  - FIXED: the address is unchanged.
  - INCR: +STRB_WIDTH per beat; 4KB crossing is not checked.
  - WRAP: wrap span W=(len+1)*STRB_WIDTH; next = (addr & ~(W-1)) | ((addr+STRB_WIDTH) & (W-1)).
- Errors:
  - Word index >= MEM_WORDS: that beat gets SLVERR. Writes are suppressed; reads return RDATA=0 with RRESP=SLVERR.
  - Burst 11, or WRAP with len not in {1,3,7,15}: the whole burst gets SLVERR and no memory writes occur.
- Channels: write and read engines run concurrently. If a read beat is fetched in the same cycle a write updates the same word, the read returns the pre-write (old) data.

Test Plan:
1. INCR write, AWID=5, addr 0x10, len 3, data 0xA0..0xA3, strb all-ones → BID=5, BRESP=00. INCR read of the same range, ARID=9 → RID=9, RDATA 0xA0..0xA3, RLAST only on the 4th beat, RRESP=00.
2. Word preloaded 0xFFFFFFFF; write 0x11223344 with WSTRB=0101 → read returns 0xFF22FF44.
3. WRAP, DATA_WIDTH=32, addr 0x18, len 3 → beats hit 0x18, 0x1C, 0x10, 0x14; the readback matches. WRAP with len 2 → SLVERR and memory unchanged.
4. Write and read at addr MEM_WORDS*4 → BRESP=10; RRESP=10 with RDATA=0. AWBURST=11 → SLVERR and no memory change.
5. Backpressure: RREADY held low 3 cycles mid-burst → RDATA/RLAST/RVALID stable throughout. BREADY held low 5 cycles → BVALID/BID stable and AWREADY stays 0.
6. ARESETn pulsed low during beat 2 of a len-7 write → all outputs 0 immediately, no B response. A subsequent read of beats 0-1 returns the written data.
